// File: rtl/skylark_mem_pkg.sv
// +--------------------------------------------------------------------+
// | skylark_mem_pkg : shared types for the data-memory responder       |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package skylark_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// +--------------------------------------------------------------------+
// | dmem_lane_align : byte enables, store replication, load extension  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_lane_align
  import skylark_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    case (addr_lo)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    byte_en   = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rword;
    case (size)
      SZ_B: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~is_unsigned & rhalf[15]}}, rhalf};
      end
      SZ_W: begin
        byte_en   = 4'b1111;
      end
      default: begin
        byte_en   = 4'b0000;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +--------------------------------------------------------------------+
// | dmem_responder : wait-stated load/store responder with local RAM   |
// | optional macro DMEM_MMIO_EN adds a word register at MMIO_ADDR      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_responder
  import skylark_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_stall
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] ram_q [DEPTH_WORDS];

  logic        accept, use_lat, fire;
  logic        a_we, a_uns;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, offset;
  logic        in_range, misalign, bad_size, mmio_hit, err, ram_we;
  logic [AW-1:0] idx;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep, rdata_ext, rword, mmio_rd;

  assign req_ready = reset & (state_q != WAIT);
  assign accept    = req_valid & req_ready;
  assign use_lat   = (state_q == WAIT);

  // The access completes either from the latched request (end of WAIT)
  // or straight from the port when a zero-wait accept happens.
  assign a_we    = use_lat ? we_q    : req_we;
  assign a_uns   = use_lat ? uns_q   : req_unsigned;
  assign a_size  = use_lat ? size_q  : req_size;
  assign a_addr  = use_lat ? addr_q  : req_addr;
  assign a_wdata = use_lat ? wdata_q : req_wdata;
  assign fire    = use_lat ? (cnt_q == 4'd0) : (accept & ZERO_WAIT);

  assign offset   = a_addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);
  assign idx      = offset[AW+1:2];
  assign misalign = ((a_size == SZ_H) & a_addr[0]) | ((a_size == SZ_W) & (a_addr[1:0] != 2'b00));
  assign bad_size = (a_size == 2'b11);
  assign rword    = ram_q[idx];

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_q, mmio_d;
  assign mmio_hit = (a_addr[31:2] == MMIO_ADDR[31:2]);
  assign mmio_rd  = mmio_q;
  assign mmio_out = mmio_q;
`else
  assign mmio_hit = 1'b0;
  assign mmio_rd  = 32'h0;
`endif

  assign err    = misalign | bad_size | (mmio_hit ? (a_size != SZ_W) : ~in_range);
  assign ram_we = fire & a_we & ~err & ~mmio_hit;

  dmem_lane_align u_align (
    .size        (a_size),
    .addr_lo     (a_addr[1:0]),
    .is_unsigned (a_uns),
    .wdata       (a_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    uns_d       = uns_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = fire;
    rsp_err_d   = fire & err;
    rsp_rdata_d = 32'h0;
    if (fire & ~err & ~a_we) begin
      rsp_rdata_d = mmio_hit ? mmio_rd : rdata_ext;
    end
`ifdef DMEM_MMIO_EN
    mmio_d = mmio_q;
    if (fire & a_we & ~err & mmio_hit) begin
      mmio_d = a_wdata;
    end
`endif
    case (state_q)
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (accept) begin
          we_d    = req_we;
          uns_d   = req_unsigned;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (ZERO_WAIT) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT - 4'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
`ifdef DMEM_MMIO_EN
      mmio_q      <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef DMEM_MMIO_EN
      mmio_q      <= mmio_d;
`endif
    end
  end

  // RAM keeps its contents across reset; writes only happen on a fire edge.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          ram_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_stall = (state_q == WAIT);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +--------------------------------------------------------------------+
// | tb_dmem_responder : scoreboard bench, one 3-wait and one 0-wait DUT|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;
  import skylark_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        a_req_valid, a_req_we, a_req_unsigned, a_req_ready, a_rsp_valid, a_rsp_err, a_mem_stall;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_we, b_req_unsigned, b_req_ready, b_rsp_valid, b_rsp_err, b_mem_stall;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
`ifdef DMEM_MMIO_EN
  logic [31:0] a_mmio_out, b_mmio_out;
`endif

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h2000), .WAIT_CYCLES(3)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_we(a_req_we), .req_size(a_req_size),
    .req_unsigned(a_req_unsigned), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .mem_stall(a_mem_stall)
`ifdef DMEM_MMIO_EN
    , .mmio_out(a_mmio_out)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h2000), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_we(b_req_we), .req_size(b_req_size),
    .req_unsigned(b_req_unsigned), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .mem_stall(b_mem_stall)
`ifdef DMEM_MMIO_EN
    , .mmio_out(b_mmio_out)
`endif
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t  qa[$];
  exp_t  qb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string step = "reset";
  logic  b_prev_stall = 1'b0;
  logic  b_stall_twice = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed 0x%08h expected 0x%08h", step, tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_rsp_valid === 1'b1) begin
      n_tests++;
      assert (qa.size() != 0) else begin
        n_fail++;
        $error("FAIL %s/a_spurious_rsp: observed rsp_valid=1 expected no response", step);
      end
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_rdata", a_rsp_rdata, e.rdata);
        check("a_err", {31'b0, a_rsp_err}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    b_stall_twice <= b_stall_twice | (b_prev_stall & b_mem_stall);
    b_prev_stall  <= b_mem_stall;
    if (b_rsp_valid === 1'b1) begin
      n_tests++;
      assert (qb.size() != 0) else begin
        n_fail++;
        $error("FAIL %s/b_spurious_rsp: observed rsp_valid=1 expected no response", step);
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_rdata", b_rsp_rdata, e.rdata);
        check("b_err", {31'b0, b_rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic issue_a(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, input logic push, input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_size = sz; a_req_unsigned = uns;
    a_req_addr = addr; a_req_wdata = wd;
    if (push) qa.push_back(exp_t'{rdata: exp_rd, err: exp_err});
    @(posedge clk);
    #1 a_req_valid = 1'b0;
  endtask

  task automatic wait_a(input int budget);
    int k = 0;
    while (qa.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    assert (qa.size() == 0) else begin
      n_fail++;
      $error("FAIL %s/a_timeout: observed %0d pending expected 0", step, qa.size());
    end
    qa.delete();
  endtask

  task automatic do_a(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    issue_a(we, sz, uns, addr, wd, 1'b1, exp_rd, exp_err);
    wait_a(20);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'b00; a_req_unsigned = 1'b0;
    a_req_addr = 32'h0; a_req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b00; b_req_unsigned = 1'b0;
    b_req_addr = 32'h0; b_req_wdata = 32'h0;
    #2;
    check("a_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
    check("a_rsp_rdata", a_rsp_rdata, 32'd0);
    check("a_rsp_err", {31'b0, a_rsp_err}, 32'd0);
    check("a_mem_stall", {31'b0, a_mem_stall}, 32'd0);
    check("b_rsp_valid", {31'b0, b_rsp_valid}, 32'd0);
`ifdef DMEM_MMIO_EN
    check("a_mmio_out", a_mmio_out, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Zero-wait DUT: store then load back-to-back from RESP.
    step = "b2b";
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = SZ_W; b_req_addr = 32'h2000; b_req_wdata = 32'hDEADBEEF;
    qb.push_back(exp_t'{rdata: 32'h0, err: 1'b0});
    @(posedge clk);
    @(negedge clk);
    check("b_sw_rsp_valid", {31'b0, b_rsp_valid}, 32'd1);
    check("b_ready_in_resp", {31'b0, b_req_ready}, 32'd1);
    b_req_we = 1'b0;
    qb.push_back(exp_t'{rdata: 32'hDEADBEEF, err: 1'b0});
    @(posedge clk);
    @(negedge clk);
    check("b_lw_rsp_valid", {31'b0, b_rsp_valid}, 32'd1);
    b_req_valid = 1'b0;
    @(negedge clk);
    check("b_idle_rsp_valid", {31'b0, b_rsp_valid}, 32'd0);
    check("b_queue_empty", 32'(qb.size()), 32'd0);
    check("b_stall_twice", {31'b0, b_stall_twice}, 32'd0);

    // Three-wait DUT: latency and stall window.
    step = "sw_a";
    do_a(1'b1, SZ_W, 1'b0, 32'h2000, 32'hDEADBEEF, 32'h0, 1'b0);
    step = "lat3";
    issue_a(1'b0, SZ_W, 1'b0, 32'h2000, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("wait_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
      check("wait_mem_stall", {31'b0, a_mem_stall}, 32'd1);
      check("wait_req_ready", {31'b0, a_req_ready}, 32'd0);
    end
    @(negedge clk);
    check("resp_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
    check("resp_mem_stall", {31'b0, a_mem_stall}, 32'd0);
    wait_a(5);

    step = "lanes";
    do_a(1'b1, SZ_W, 1'b0, 32'h2000, 32'h11223344, 32'h0, 1'b0);
    do_a(1'b1, SZ_B, 1'b0, 32'h2001, 32'h00000080, 32'h0, 1'b0);
    do_a(1'b0, SZ_B, 1'b0, 32'h2001, 32'h0, 32'hFFFFFF80, 1'b0);
    do_a(1'b0, SZ_B, 1'b1, 32'h2001, 32'h0, 32'h00000080, 1'b0);
    do_a(1'b0, SZ_W, 1'b0, 32'h2000, 32'h0, 32'h11228044, 1'b0);
    do_a(1'b0, SZ_H, 1'b0, 32'h2000, 32'h0, 32'hFFFF8044, 1'b0);
    do_a(1'b0, SZ_H, 1'b1, 32'h2000, 32'h0, 32'h00008044, 1'b0);
    do_a(1'b0, SZ_H, 1'b0, 32'h2002, 32'h0, 32'h00001122, 1'b0);

    step = "errors";
    do_a(1'b0, SZ_H, 1'b0, 32'h2003, 32'h0, 32'h0, 1'b1);
    do_a(1'b1, SZ_W, 1'b0, 32'h2002, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_a(1'b1, 2'b11, 1'b0, 32'h2000, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_a(1'b0, SZ_W, 1'b0, 32'h1FFC, 32'h0, 32'h0, 1'b1);
    do_a(1'b0, SZ_W, 1'b0, 32'h2000, 32'h0, 32'h11228044, 1'b0);

    step = "top_edge";
    do_a(1'b1, SZ_W, 1'b0, 32'h2FFC, 32'hA5A55A5A, 32'h0, 1'b0);
    do_a(1'b0, SZ_W, 1'b0, 32'h2FFC, 32'h0, 32'hA5A55A5A, 1'b0);
    do_a(1'b0, SZ_W, 1'b0, 32'h3000, 32'h0, 32'h0, 1'b1);

    step = "rst_wait";
    issue_a(1'b1, SZ_W, 1'b0, 32'h2000, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, a_rsp_err}, 32'd0);
    check("rst_mem_stall", {31'b0, a_mem_stall}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    do_a(1'b0, SZ_W, 1'b0, 32'h2000, 32'h0, 32'h11228044, 1'b0);

`ifdef DMEM_MMIO_EN
    step = "mmio";
    do_a(1'b1, SZ_W, 1'b0, 32'hFFFFFFF0, 32'h00000001, 32'h0, 1'b0);
    check("mmio_out", a_mmio_out, 32'd1);
    do_a(1'b0, SZ_W, 1'b0, 32'hFFFFFFF0, 32'h0, 32'h00000001, 1'b0);
    do_a(1'b1, SZ_B, 1'b0, 32'hFFFFFFF0, 32'h000000FF, 32'h0, 1'b1);
    check("mmio_out_kept", a_mmio_out, 32'd1);
`else
    step = "no_mmio";
    do_a(1'b0, SZ_W, 1'b0, 32'hFFFFFFF0, 32'h0, 32'h0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
